// File: rtl/fixed_vector_mac.sv
// fixed_vector_mac: LANES-wide signed dot product accumulated over ACC_LEN beats, result on a valid/ready output
// Ports: core_clk/rst (sync, active-high); clear flushes the partial sum and the in-flight beat;
//   a/b/in_valid/in_ready operand beat handshake (lane i at [i*IN_WIDTH +: IN_WIDTH]);
//   out_data/out_valid/out_ready result handshake; beat_count beats absorbed into the partial sum.
module fixed_vector_mac #(
  parameter int IN_WIDTH = 16,
  parameter int ACC_WIDTH = 40,
  parameter int LANES = 4,
  parameter int ACC_LEN = 8
) (
  input  logic                          core_clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic [LANES*IN_WIDTH-1:0]     a,
  input  logic [LANES*IN_WIDTH-1:0]     b,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [ACC_WIDTH-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(ACC_LEN):0]      beat_count
);
  localparam int PW = 2 * IN_WIDTH;
  localparam int BW = $clog2(ACC_LEN) + 1;
  if (ACC_WIDTH < PW) begin : g_width_check
    $error("fixed_vector_mac: ACC_WIDTH must be at least 2*IN_WIDTH");
  end
  logic en, take, fire, last;
  logic p_valid_q, p_valid_d;
  logic signed [PW-1:0] prod_q [LANES];
  logic signed [PW-1:0] prod_d [LANES];
  logic signed [ACC_WIDTH-1:0] sum, acc_q, acc_d, out_data_q, out_data_d;
  logic out_valid_q, out_valid_d;
  logic [BW-1:0] beat_q, beat_d;
  // a result waiting on a stalled consumer freezes both pipeline stages
  assign en = !(out_valid_q && !out_ready);
  assign in_ready = en && !clear && !rst;
  assign take = in_valid && in_ready;
  assign fire = en && p_valid_q && !clear;
  assign last = beat_q == BW'(ACC_LEN - 1);
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = PW'($signed(a[i*IN_WIDTH +: IN_WIDTH])) * PW'($signed(b[i*IN_WIDTH +: IN_WIDTH]));
      sum = sum + ACC_WIDTH'(prod_q[i]);
    end
  end
  always_comb begin
    p_valid_d = clear ? 1'b0 : en ? take : p_valid_q;
    acc_d = clear ? '0 : fire ? (last ? '0 : acc_q + sum) : acc_q;
    beat_d = clear ? '0 : fire ? (last ? '0 : beat_q + 1'b1) : beat_q;
    // a fresh final beat wins over the handshake that would otherwise drop out_valid
    out_valid_d = (fire && last) || (out_valid_q && !out_ready);
    out_data_d = fire && last ? acc_q + sum : out_data_q;
  end
  always_ff @(posedge core_clk) begin
    if (rst) begin
      p_valid_q <= 1'b0;
      acc_q <= '0;
      beat_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else begin
      p_valid_q <= p_valid_d;
      acc_q <= acc_d;
      beat_q <= beat_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      if (take) for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
    end
  end
  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  assign beat_count = beat_q;
endmodule

// File: tb/tb_fixed_vector_mac.sv
// tb_fixed_vector_mac: directed, table-driven and randomized checks of three fixed_vector_mac configurations
module tb_fixed_vector_mac;
  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [39:0] exp;
  } vec_t;
  logic core_clk = 1'b0;
  logic rst, clear, out_ready, took;
  logic [63:0] a, b;
  logic iv [3];
  logic ir [3];
  logic ov [3];
  logic [39:0] od0, od1;
  logic [31:0] od2;
  logic [3:0] bc0;
  logic bc1;
  logic [1:0] bc2;
  int sel, n_cmp, n_bad;
  int n_out [3];
  int len [3] = '{8, 1, 2};
  int wid [3] = '{40, 40, 32};
  longint part_acc [3];
  int part_n [3];
  longint q [3][$];
  vec_t tv [12];
  always #5 core_clk = ~core_clk;
  fixed_vector_mac u0 (.core_clk(core_clk), .rst(rst), .clear(clear), .a(a), .b(b), .in_valid(iv[0]),
    .in_ready(ir[0]), .out_data(od0), .out_valid(ov[0]), .out_ready(out_ready), .beat_count(bc0));
  fixed_vector_mac #(.ACC_LEN(1)) u1 (.core_clk(core_clk), .rst(rst), .clear(clear), .a(a), .b(b),
    .in_valid(iv[1]), .in_ready(ir[1]), .out_data(od1), .out_valid(ov[1]), .out_ready(out_ready), .beat_count(bc1));
  fixed_vector_mac #(.ACC_LEN(2), .ACC_WIDTH(32)) u2 (.core_clk(core_clk), .rst(rst), .clear(clear), .a(a), .b(b),
    .in_valid(iv[2]), .in_ready(ir[2]), .out_data(od2), .out_valid(ov[2]), .out_ready(out_ready), .beat_count(bc2));
  task automatic chk(string nm, logic [39:0] act, logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step();
    logic r, v;
    logic [39:0] d;
    longint dot;
    #1;
    r = ir[sel];
    v = ov[sel];
    d = sel == 0 ? od0 : sel == 1 ? od1 : {8'd0, od2};
    took = iv[sel] && r;
    if (rst || clear) chk("in_ready_blocked", 40'(r), 40'd0);
    if (v && !out_ready) begin
      chk("in_ready_stalled", 40'(r), 40'd0);
      if (q[sel].size() > 0) chk("stall_data", d, 40'(q[sel][0]));
    end
    if (v && out_ready && !rst) begin
      n_out[sel]++;
      if (q[sel].size() == 0) chk("spurious_out", 40'(v), 40'd0);
      else chk("result", d, 40'(q[sel].pop_front()));
    end
    if (took) begin
      dot = 0;
      for (int i = 0; i < 4; i++) dot += longint'($signed(a[i*16 +: 16])) * longint'($signed(b[i*16 +: 16]));
      part_acc[sel] += dot;
      part_n[sel]++;
      if (part_n[sel] == len[sel]) begin
        q[sel].push_back(part_acc[sel] & ((longint'(1) << wid[sel]) - 1));
        part_acc[sel] = 0;
        part_n[sel] = 0;
      end
    end
    if (rst || clear) begin
      for (int s = 0; s < 3; s++) begin
        part_acc[s] = 0;
        part_n[s] = 0;
        if (rst) q[s].delete();
      end
    end
    @(negedge core_clk);
  endtask
  task automatic stream(int n, bit bp);
    int idx = 0;
    int cyc = 0;
    int stall_n = 0;
    int base = n_out[sel];
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    while ((idx < n || q[sel].size() > 0) && cyc < 1000) begin
      iv[sel] = idx < n && (bp || $urandom_range(0, 3) != 0);
      if (bp) begin
        out_ready = !(ov[sel] && stall_n < 5);
        if (!out_ready) stall_n++;
      end else out_ready = $urandom_range(0, 3) != 0;
      step();
      if (took) begin
        idx++;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
      end
      cyc++;
    end
    iv[sel] = 1'b0;
    out_ready = 1'b1;
    chk("stream_bounded", 40'(cyc < 1000), 40'd1);
    chk("stream_results", 40'(n_out[sel] - base), 40'(n / len[sel]));
    if (bp) chk("stall_cycles", 40'(stall_n), 40'd5);
  endtask
  initial begin
    for (int k = 1; k <= 10; k++) tv[k-1] = '{{48'd0, 16'(k)}, {48'd0, 16'(k)}, 40'(k * k)};
    tv[10] = '{{4{16'h8000}}, {4{16'h8000}}, 40'h0100000000};
    tv[11] = '{{16'hFFFB, 16'd100, 16'h8000, 16'h7FFF}, {16'hFFF9, 16'hFFFD, 16'h7FFF, 16'h7FFF}, 40'hFFFFFF7EF8};
    rst = 1'b1;
    clear = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    sel = 0;
    n_cmp = 0;
    n_bad = 0;
    for (int s = 0; s < 3; s++) begin
      iv[s] = 1'b0;
      n_out[s] = 0;
      part_acc[s] = 0;
      part_n[s] = 0;
    end
    @(negedge core_clk);
    step();
    step();
    chk("rst_out_valid", 40'(ov[0]), 40'd0);
    chk("rst_out_data", od0, 40'd0);
    chk("rst_beat_count", 40'(bc0), 40'd0);
    rst = 1'b0;
    #1 chk("in_ready_after_rst", 40'(ir[0]), 40'd1);
    @(negedge core_clk);
    sel = 2;
    iv[2] = 1'b1;
    a = {16'd4, 16'd3, 16'd2, 16'd1};
    b = {4{16'd1}};
    step();
    a = {16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF};
    b = {4{16'd2}};
    step();
    iv[2] = 1'b0;
    chk("latency_not_early", 40'(ov[2]), 40'd0);
    step();
    chk("latency_valid", 40'(ov[2]), 40'd1);
    chk("dot_neg10", 40'(od2), 40'h00FFFFFFF6);
    step();
    a = {4{16'h8000}};
    b = a;
    iv[2] = 1'b1;
    step();
    step();
    iv[2] = 1'b0;
    step();
    chk("wrap32_valid", 40'(ov[2]), 40'd1);
    chk("wrap32_zero", 40'(od2), 40'd0);
    step();
    sel = 0;
    iv[0] = 1'b1;
    repeat (8) step();
    iv[0] = 1'b0;
    step();
    chk("extreme_valid", 40'(ov[0]), 40'd1);
    chk("extreme_2pow35", od0, 40'h0800000000);
    step();
    sel = 1;
    for (int i = 0; i < 13; i++) begin
      if (i < 12) begin
        a = tv[i].a;
        b = tv[i].b;
        iv[1] = 1'b1;
      end else iv[1] = 1'b0;
      step();
      if (i > 0) begin
        chk($sformatf("table_valid_%0d", i - 1), 40'(ov[1]), 40'd1);
        chk($sformatf("table_data_%0d", i - 1), od1, tv[i-1].exp);
      end
    end
    step();
    sel = 0;
    stream(16, 1'b1);
    iv[0] = 1'b1;
    repeat (3) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      step();
    end
    chk("bc_before_clear", 40'(bc0), 40'd2);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("bc_after_clear", 40'(bc0), 40'd0);
    chk("clear_no_out", 40'(ov[0]), 40'd0);
    a = {4{16'd1}};
    b = a;
    step();
    step();
    chk("bc_restart", 40'(bc0), 40'd1);
    repeat (6) step();
    iv[0] = 1'b0;
    step();
    chk("clear_result_valid", 40'(ov[0]), 40'd1);
    chk("clear_result", od0, 40'd32);
    step();
    iv[0] = 1'b1;
    repeat (3) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      step();
    end
    iv[0] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_valid", 40'(ov[0]), 40'd0);
    chk("rst_mid_data", od0, 40'd0);
    chk("rst_mid_bc", 40'(bc0), 40'd0);
    a = {4{16'd1}};
    b = a;
    iv[0] = 1'b1;
    out_ready = 1'b0;
    repeat (8) step();
    iv[0] = 1'b0;
    step();
    chk("pending_before_rst", 40'(ov[0]), 40'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_pending_valid", 40'(ov[0]), 40'd0);
    chk("rst_pending_data", od0, 40'd0);
    out_ready = 1'b1;
    a = {4{16'd2}};
    b = a;
    iv[0] = 1'b1;
    repeat (8) step();
    iv[0] = 1'b0;
    step();
    chk("post_rst_valid", 40'(ov[0]), 40'd1);
    chk("post_rst_result", od0, 40'd128);
    step();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      stream(s == 0 ? 64 : 40, 1'b0);
    end
    for (int s = 0; s < 3; s++) chk($sformatf("queue_empty_%0d", s), 40'(q[s].size()), 40'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fixed_vector_mac.md
# fixed_vector_mac

Parametrised, pipelined successor to the scalar fixed-point multiply-accumulate. Each beat it takes LANES signed operand pairs, sums their products and accumulates that sum over ACC_LEN beats. It then emits one ACC_WIDTH result through a valid/ready output with full backpressure. The block is the dot-product engine inside the fixed-point linear and matmul datapaths.

## Interface
- IN_WIDTH, 16, signed two's-complement width of each operand lane.
- ACC_WIDTH, 40, accumulator and result width; must be ≥ 2*IN_WIDTH + clog2(LANES*ACC_LEN) for overflow-free use. Elaboration error if < 2*IN_WIDTH.
- LANES, 4, operand pairs per beat (≥1).
- ACC_LEN, 8, beats accumulated per result (≥1).

Ports:
- core_clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- clear  in  1  synchronous flush of partial accumulation and in-flight beat.
- a  in  LANES*IN_WIDTH  operand A; lane i at bits [i*IN_WIDTH +: IN_WIDTH].
- b  in  LANES*IN_WIDTH  operand B, same packing.
- in_valid  in  1  beat on a/b valid.
- in_ready  out  1  block accepts beat this cycle.
- out_data  out  ACC_WIDTH  signed accumulated result.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts result.
- beat_count  out  clog2(ACC_LEN)+1  beats absorbed into current partial sum.

## Operation
- Stage P: on accept (in_valid & in_ready), register LANES products a_i*b_i, each 2*IN_WIDTH signed; set p_valid.
- Stage A: when en & p_valid, compute tree sum of the P products, sign-extended to ACC_WIDTH. Add it to acc, wrapping modulo 2^ACC_WIDTH; no saturation.
- en = !(out_valid & !out_ready). in_ready = en & !clear & !rst.
- When en and not accepting, p_valid clears.
- Final beat: when the consumed P beat has beat_count == ACC_LEN-1:
  - out_data <= acc + sum; out_valid <= 1.
  - acc <= 0; beat_count <= 0.
- Non-final beat: acc <= acc + sum; beat_count++.
- out_valid clears on out_valid & out_ready, unless a new final beat lands the same edge. In that case out_data is replaced and out_valid stays 1.
- When en=0 (result stalled):
  - P, acc and beat_count hold.
  - in_ready=0.
  - out_data is stable.
- clear (no rst):
  - acc <= 0, beat_count <= 0, p_valid <= 0.
  - The in-flight beat is dropped; no beat is accepted that cycle.
  - A pending out_valid/out_data is unaffected and may still handshake that cycle.
- rst: overrides everything.
  - acc, P registers, beat_count = 0.
  - out_valid = 0, out_data = 0.
  - in_ready = 0 during rst; 1 from the first cycle after rst deasserts.

## Timing
- Reset values: out_valid=0, out_data=0, beat_count=0, in_ready=0 while rst=1.
- Latency: last beat accepted at edge k gives out_valid=1 after edge k+1 (2-cycle pipeline).
- Throughput: 1 beat/cycle sustained with out_ready=1, including back-to-back results when ACC_LEN=1.
- Backpressure: stalling out_ready freezes the whole pipeline. No beat is lost or duplicated; in_ready falls combinationally with out_valid & !out_ready.
- Handshake: out_data/out_valid hold until accepted. in_valid may drop without penalty; gaps do not disturb acc.
- Simultaneous events:
  - out handshake + new final result on the same edge: new result presented next cycle, no bubble.
  - clear + in_valid: beat rejected.
  - rst mid-accumulation: partial sum lost, no output.

## Test plan
- Single result, LANES=4, ACC_LEN=2: beats a={1,2,3,4}, b={1,1,1,1}, then a={-1,-2,-3,-4}, b={2,2,2,2} -> one result out_data=-10, out_valid 2 cycles after beat 2.
- Signed extremes, IN_WIDTH=16: all lanes a=b=-32768 for 8 beats -> out_data = 4*8*2^30 = 2^35. ACC_WIDTH=40 gives no wrap; ACC_WIDTH=32 wraps to 0.
- Backpressure: hold out_ready=0 for 5 cycles with a result pending and beats streaming -> in_ready=0, out_data stable. Next result is correct after release; total beats accepted equals beats offered.
- ACC_LEN=1 streaming with out_ready=1: beats a=b={k,0,0,0} for k=1..10 -> outputs 1,4,...,100 on consecutive cycles.
- clear after 3 of 8 beats, then 8 beats of a=b={1,1,1,1} -> single result 32, beat_count restarts from 0.
- rst asserted mid-accumulation and while out_valid=1 -> out_valid=0, out_data=0 next cycle. The next result equals only post-reset beats.
